// File: rtl/dice_game_ctrl.sv
// Purpose : two-player turn controller for the six-face dice counter.
// Latency : button seen at an edge -> roll next cycle; last ROLL cycle -> result_valid two edges later.
// Backpr. : none; buttons are level requests, and anything seen outside IDLE/ROLL is ignored.
//
// Ports:
//    clk, res            clock, async active-high reset
//    btn0, btn1          player roll requests (level); only the turn player's button counts
//    face                current dice value from the dice counter (legal 1..6)
//    roll                advance enable to the dice counter, high exactly in ROLL
//    turn                player whose turn it is
//    result              last latched face
//    result_valid        one-cycle pulse while result and the score are fresh
//    score0, score1      accumulated scores
//    winner_valid        sticky game-over flag
//    winner              winning player (meaningful while winner_valid)
//    err                 sticky flag: an illegal face (0 or 7) was latched
module dice_game_ctrl #(
   parameter int TARGET   = 20,
   parameter int MIN_ROLL = 4,
   parameter int SCORE_W  = 6
) (
   input  logic               clk,
   input  logic               res,
   input  logic               btn0,
   input  logic               btn1,
   input  logic [2:0]         face,
   output logic               roll,
   output logic               turn,
   output logic [2:0]         result,
   output logic               result_valid,
   output logic [SCORE_W-1:0] score0,
   output logic [SCORE_W-1:0] score1,
   output logic               winner_valid,
   output logic               winner,
   output logic               err
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_ROLL   = 3'd1;
   localparam logic [2:0] S_SETTLE = 3'd2;
   localparam logic [2:0] S_SCORE  = 3'd3;
   localparam logic [2:0] S_DONE   = 3'd4;

   // rcnt only has to tell "minimum reached" from "not yet", so it saturates
   // at MIN_ROLL-1 instead of growing without bound while a button is held.
   localparam int               RCNT_W    = (MIN_ROLL > 1) ? $clog2(MIN_ROLL) : 1;
   localparam logic [RCNT_W-1:0] RCNT_LAST = RCNT_W'(MIN_ROLL - 1);
   localparam logic [SCORE_W-1:0] TARGET_S = SCORE_W'(TARGET);

   logic [2:0]         state;
   logic [2:0]         state_nxt;
   logic [RCNT_W-1:0]  rcnt;
   logic               btn_turn;
   logic               face_ok;
   logic [SCORE_W-1:0] face_add;
   logic [SCORE_W-1:0] turn_score;
   logic               win;

   assign btn_turn   = turn ? btn1 : btn0;
   assign face_ok    = (face != 3'd0) && (face != 3'd7);
   assign face_add   = face_ok ? SCORE_W'(face) : '0;
   assign turn_score = turn ? score1 : score0;
   assign win        = (turn_score >= TARGET_S);

   // Pure state decode: no path from the buttons, and it falls with res.
   assign roll = (state == S_ROLL);

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (btn_turn) state_nxt = S_ROLL;
         // An early release is held off until the minimum count is reached.
         S_ROLL:   if (!btn_turn && (rcnt == RCNT_LAST)) state_nxt = S_SETTLE;
         S_SETTLE: state_nxt = S_SCORE;
         S_SCORE:  state_nxt = win ? S_DONE : S_IDLE;
         S_DONE:   state_nxt = S_DONE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         state        <= S_IDLE;
         rcnt         <= '0;
         turn         <= 1'b0;
         result       <= 3'd0;
         result_valid <= 1'b0;
         score0       <= '0;
         score1       <= '0;
         winner_valid <= 1'b0;
         winner       <= 1'b0;
         err          <= 1'b0;
      end else begin
         state        <= state_nxt;
         result_valid <= 1'b0;
         case (state)
            S_IDLE: rcnt <= '0;
            S_ROLL: if (rcnt != RCNT_LAST) rcnt <= rcnt + 1'b1;
            S_SETTLE: begin
               // face has been stable for a cycle (roll was low), so latch it.
               rcnt         <= '0;
               result       <= face;
               result_valid <= 1'b1;
               if (turn) score1 <= score1 + face_add;
               else      score0 <= score0 + face_add;
               if (!face_ok) err <= 1'b1;
            end
            S_SCORE: begin
               if (win) begin
                  winner       <= turn;
                  winner_valid <= 1'b1;
               end else begin
                  turn <= ~turn;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_dice_game_ctrl.sv
// Purpose : self-checking bench for dice_game_ctrl with a behavioural dice counter.
// Latency : n/a (bench).
// Backpr. : n/a (bench).
module tb_dice_game_ctrl;

   localparam int TARGET   = 20;
   localparam int MIN_ROLL = 4;
   localparam int SCORE_W  = 6;

   logic               clk = 1'b0;
   logic               res = 1'b1;
   logic               btn0 = 1'b0;
   logic               btn1 = 1'b0;
   logic [2:0]         face;
   logic               roll;
   logic               turn;
   logic [2:0]         result;
   logic               result_valid;
   logic [SCORE_W-1:0] score0;
   logic [SCORE_W-1:0] score1;
   logic               winner_valid;
   logic               winner;
   logic               err;

   // Dice counter model: preloadable, advances 1..6 while roll is high.
   logic [2:0] dice = 3'd1;
   logic       dice_set = 1'b0;
   logic [2:0] dice_set_val = 3'd1;
   logic       face_ovr = 1'b0;

   assign face = face_ovr ? 3'd7 : dice;

   always @(posedge clk) begin
      if (dice_set)  dice <= dice_set_val;
      else if (roll) dice <= (dice >= 3'd6) ? 3'd1 : dice + 3'd1;
   end

   always #5 clk = ~clk;

   dice_game_ctrl #(.TARGET(TARGET), .MIN_ROLL(MIN_ROLL), .SCORE_W(SCORE_W)) dut (
      .clk(clk), .res(res), .btn0(btn0), .btn1(btn1), .face(face),
      .roll(roll), .turn(turn), .result(result), .result_valid(result_valid),
      .score0(score0), .score1(score1), .winner_valid(winner_valid),
      .winner(winner), .err(err)
   );

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
   endtask

   typedef struct {
      int res_v;
      int s0;
      int s1;
      int err_v;
   } exp_t;

   exp_t sb[$];

   // Bench model of the game.
   int m_s0 = 0, m_s1 = 0, m_turn = 0, m_err = 0, m_done = 0, m_winner = 0;

   // Scoreboard consumer: every result_valid pulse must match the oldest prediction.
   always @(negedge clk) begin
      if (result_valid && !res) begin
         if (sb.size() == 0) begin
            chk("sb_unexpected_result", 1, 0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("result", int'(result), e.res_v);
            chk("score0", int'(score0), e.s0);
            chk("score1", int'(score1), e.s1);
            chk("err", int'(err), e.err_v);
         end
      end
   end

   task automatic chk_reset_vals(input string pfx);
      chk({pfx, "_roll"}, int'(roll), 0);
      chk({pfx, "_turn"}, int'(turn), 0);
      chk({pfx, "_result"}, int'(result), 0);
      chk({pfx, "_rvalid"}, int'(result_valid), 0);
      chk({pfx, "_score0"}, int'(score0), 0);
      chk({pfx, "_score1"}, int'(score1), 0);
      chk({pfx, "_wvalid"}, int'(winner_valid), 0);
      chk({pfx, "_winner"}, int'(winner), 0);
      chk({pfx, "_err"}, int'(err), 0);
   endtask

   // One turn for player p: preload the dice, hold p's button for h edges
   // (the IDLE->ROLL edge included), optionally force face=7 during SETTLE.
   // Called at a negedge with the DUT in IDLE; returns at a negedge.
   task automatic do_turn(input int p, input int h, input int start, input int f7);
      int   n_exp, fexp, rolls, cyc, got, seen_roll;
      exp_t e;
      n_exp = (h > MIN_ROLL) ? h : MIN_ROLL;
      fexp  = f7 ? 7 : (((start - 1 + n_exp) % 6) + 1);
      if (fexp >= 1 && fexp <= 6) begin
         if (p == 1) m_s1 += fexp;
         else        m_s0 += fexp;
      end else begin
         m_err = 1;
      end
      e.res_v = fexp; e.s0 = m_s0; e.s1 = m_s1; e.err_v = m_err;
      sb.push_back(e);
      if (((p == 1) ? m_s1 : m_s0) >= TARGET) begin
         m_done = 1; m_winner = p;
      end else begin
         m_turn = 1 - p;
      end

      dice_set_val = 3'(start);
      dice_set     = 1'b1;
      if (p == 1) btn1 = 1'b1;
      else        btn0 = 1'b1;
      rolls = 0; cyc = 0; got = 0; seen_roll = 0;
      while (!got && cyc < 200) begin
         @(posedge clk);
         #1;
         cyc++;
         dice_set = 1'b0;
         if (cyc >= h) begin
            if (p == 1) btn1 = 1'b0;
            else        btn0 = 1'b0;
         end
         @(negedge clk);
         if (face_ovr) face_ovr = 1'b0;
         if (roll) begin
            rolls++;
            seen_roll = 1;
         end else if (seen_roll && f7 && !result_valid) begin
            face_ovr = 1'b1;
            seen_roll = 0;
         end
         if (result_valid) got = 1;
      end
      if (!got) chk("timeout_result_valid", 0, 1);
      chk("roll_cycles", rolls, n_exp);
      @(negedge clk);
      chk("rvalid_pulse", int'(result_valid), 0);
      chk("turn_after", int'(turn), m_turn);
      chk("wvalid_after", int'(winner_valid), m_done);
      if (m_done != 0) chk("winner", int'(winner), m_winner);
   endtask

   initial begin
      int any_roll;
      #2;
      chk_reset_vals("rst");
      @(negedge clk);
      res = 1'b0;
      @(negedge clk);

      // Player 0 pulse with btn1 held throughout: 4 roll cycles, 1 -> 5.
      btn1 = 1'b1;
      do_turn(0, 1, 1, 0);
      // btn1 already high: enters ROLL on the next edge, rolls 6 cycles, 3 -> 3.
      do_turn(1, 6, 3, 0);
      // btn0 held 10 cycles from face 2: 10 advances wrapping to 6.
      do_turn(0, 10, 2, 0);
      // Illegal face forced at SETTLE.
      do_turn(1, 1, 1, 1);
      do_turn(0, 4, 2, 0);
      do_turn(1, 1, 1, 0);
      chk("err_sticky", int'(err), 1);
      // 17 + 5 = 22 >= TARGET: player 0 wins.
      do_turn(0, 1, 1, 0);
      chk("done_turn", int'(turn), 0);

      // Presses after the game is decided are ignored.
      btn0 = 1'b1; btn1 = 1'b1;
      any_roll = 0;
      repeat (8) begin
         @(negedge clk);
         if (roll) any_roll = 1;
      end
      btn0 = 1'b0; btn1 = 1'b0;
      chk("done_no_roll", any_roll, 0);
      chk("done_score0", int'(score0), 22);
      chk("done_score1", int'(score1), 8);
      chk("done_result", int'(result), 5);
      chk("done_wvalid", int'(winner_valid), 1);

      // Reset during the 2nd ROLL cycle.
      res = 1'b1;
      @(negedge clk);
      res = 1'b0;
      m_s0 = 0; m_s1 = 0; m_turn = 0; m_err = 0; m_done = 0; m_winner = 0;
      @(negedge clk);
      btn0 = 1'b1;
      @(posedge clk);
      #1 btn0 = 1'b0;
      @(posedge clk);
      #1;
      chk("midroll_roll_before", int'(roll), 1);
      #1 res = 1'b1;
      #1;
      chk_reset_vals("midroll");
      @(negedge clk);
      res = 1'b0;
      @(negedge clk);
      chk("post_rst_roll", int'(roll), 0);
      chk("post_rst_turn", int'(turn), 0);
      // Normal play resumes: 4 -> 2.
      do_turn(0, 1, 4, 0);

      chk("sb_drained", sb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/dice_game_ctrl.md
# dice_game_ctrl

Two-player turn controller for the six-face dice counter. It arbitrates the single dice between two roll buttons and drives the dice's advance enable while the player whose turn it is holds their button, enforcing a minimum roll length. It latches each final face, accumulates per-player scores, alternates turns, and declares a winner at a target score. It sits beside the dice counter; both share `clk` and `res`.

## Interface
- `TARGET`, default 20: winning score. Requires `TARGET <= 2**SCORE_W - 7`.
- `MIN_ROLL`, default 4: minimum number of `roll` cycles per turn. Requires `MIN_ROLL >= 1`.
- `SCORE_W`, default 6: score register width.

- `clk`  in  1  clock; all state updates on the rising edge.
- `res`  in  1  reset, asynchronous, active-high.
- `btn0`  in  1  player 0 roll request, level.
- `btn1`  in  1  player 1 roll request, level.
- `face`  in  3  current dice value from the dice counter (legal values 1..6).
- `roll`  out  1  advance enable to the dice counter's `s` input.
- `turn`  out  1  player whose turn it is.
- `result`  out  3  last latched face.
- `result_valid`  out  1  one-cycle pulse when `result` and the score update.
- `score0`, `score1`  out  SCORE_W  accumulated scores.
- `winner_valid`  out  1  high once the game is decided; stays high until reset.
- `winner`  out  1  winning player; meaningful only while `winner_valid` is high.
- `err`  out  1  sticky flag: an illegal `face` (0 or 7) was latched.

## Operation
- States: IDLE, ROLL, SETTLE, SCORE, DONE.
- `roll` is decoded from the state register. It is 1 exactly in ROLL and has no combinational path from the buttons.
- IDLE -> ROLL when the button of the `turn` player is 1 at the edge. The other player's button is ignored in every state.
- ROLL:
  - `rcnt` is 0 in the first ROLL cycle and increments each ROLL cycle.
  - ROLL -> SETTLE at the edge where the turn player's button is 0 and `rcnt >= MIN_ROLL-1`.
  - A button released early does not stop the roll; ROLL continues until `MIN_ROLL` cycles have elapsed.
  - A button held indefinitely keeps the controller in ROLL.
- SETTLE: one cycle with `roll=0`, so `face` holds its final value. At the edge leaving SETTLE:
  - `result <= face`.
  - The turn player's score increases by `face`.
  - `result_valid <= 1`.
  - If `face` is 0 or 7: `err <= 1`, the score increase is 0, and `result` still takes `face`.
- SCORE: `result_valid=1` for this cycle only. At the edge leaving SCORE:
  - If the turn player's score is `>= TARGET`: go to DONE, `winner <= turn`, `winner_valid <= 1`, and `turn` is unchanged.
  - Otherwise `turn` toggles and the state returns to IDLE.
- DONE: absorbing. `roll=0`, scores and `result` are frozen, buttons are ignored. Only `res` leaves DONE.
- Scores never exceed `TARGET+5`, so there is no overflow under the parameter constraint. Scores do not saturate or wrap.

## Timing
- Reset values: state IDLE, `roll=0`, `turn=0`, `result=0`, `result_valid=0`, `score0=score1=0`, `winner_valid=0`, `winner=0`, `err=0`, `rcnt=0`.
- Reset asserted mid-operation (including mid-ROLL) clears everything immediately and asynchronously. `roll` drops in the same cycle.
- Latency:
  - Button sampled high -> `roll` high on the next cycle.
  - Minimum turn length is `1 + MIN_ROLL + 1 + 1` cycles (IDLE, ROLL, SETTLE, SCORE).
  - Last ROLL cycle -> `result_valid` two edges later.
- Dice advances per turn equal the number of ROLL cycles. For a held button, that is `max(MIN_ROLL, cycles the button is held after entering ROLL + 1)`.
- `btn0` and `btn1` high simultaneously: only the `turn` player's button counts; there is no tie condition.

## Test plan
- Default parameters, face=1, `btn0` pulsed high for 1 cycle -> `roll` high exactly 4 cycles, face=5, `result=5` with `result_valid` a 1-cycle pulse, `score0=5`, `turn=1`.
- `btn1` held throughout player 0's turn -> no effect until `turn=1`. Then the controller enters ROLL on the next edge and rolls for as long as `btn1` stays high, with a minimum of 4 cycles.
- `btn0` held 10 cycles with face=2 before the roll -> 10 ROLL cycles, face wraps 2 -> 6 -> 1 -> 6, `result=6`.
- Alternating turns until `score0` goes from 17 to 22 -> `winner_valid=1`, `winner=0`, `turn=0`. Further presses of either button leave `roll=0` and the scores frozen.
- Dice model forced to `face=7` at SETTLE -> `err=1` (and it stays 1), score unchanged, `result=7`, turn advances normally.
- `res` pulsed during the 2nd ROLL cycle -> `roll=0` and all outputs at reset values within the same cycle. After release, IDLE with `turn=0`.
